// File: rtl/activation_collector.sv
// rtl/activation_collector.sv - hard-sigmoid activation and per-layer vector packing
module activation_collector #(
    parameter int NEURON_NUM          = 5,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int FRACTION            = 8,
    parameter int SW                  = $clog2(NEURON_NUM) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [SW-1:0]                          layer_size,
    input  logic                                   layer_size_valid,
    output logic                                   layer_size_ready,
    input  logic [NEURON_OUTPUT_WIDTH-1:0]         sum_in,
    input  logic                                   sum_overflow,
    input  logic                                   sum_valid,
    output logic                                   sum_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] activations,
    output logic [NEURON_NUM-1:0]                  overflow_flags,
    output logic                                   activations_valid,
    input  logic                                   activations_ready
);
    localparam int AW = ACTIVATION_WIDTH;
    localparam int TW = NEURON_OUTPUT_WIDTH + 2;
    localparam logic signed [TW-1:0] HALF = TW'(1 << (FRACTION - 1));
    localparam logic signed [TW-1:0] YMAX = TW'((1 << (AW - 1)) - 1);
    localparam logic [SW-1:0] NMAX = SW'(NEURON_NUM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t state, state_next;
    logic [SW-1:0] size;
    logic [SW-1:0] count;
    logic [SW-1:0] size_clamped;
    logic signed [TW-1:0] sum_ext;
    logic signed [TW-1:0] t;
    logic [AW-1:0] y;
    logic sum_accept;

    assign size_clamped = (layer_size > NMAX) ? NMAX : layer_size;
    assign layer_size_ready  = (state == IDLE);
    assign sum_ready         = (state == COLLECT);
    assign activations_valid = (state == FULL);
    assign sum_accept        = sum_valid && (state == COLLECT);

    // Overflowed sums saturate by sign instead of going through the linear segment.
    always_comb begin
        sum_ext = TW'($signed(sum_in));
        t       = (sum_ext >>> 2) + HALF;
        y       = '0;
        if (sum_overflow) begin
            y = sum_in[NEURON_OUTPUT_WIDTH-1] ? '0 : YMAX[AW-1:0];
        end else if (t[TW-1]) begin
            y = '0;
        end else if (t > YMAX) begin
            y = YMAX[AW-1:0];
        end else begin
            y = t[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (layer_size_valid) begin
                    state_next = (size_clamped == '0) ? FULL : COLLECT;
                end
            end
            COLLECT: begin
                if (sum_valid && count == size - SW'(1)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (activations_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size           <= '0;
            count          <= '0;
            activations    <= '0;
            overflow_flags <= '0;
        end else begin
            if (state == IDLE && layer_size_valid) begin
                size <= size_clamped;
            end
            if (sum_accept) begin
                count <= count + SW'(1);
                for (int i = 0; i < NEURON_NUM; i++) begin
                    if (count == SW'(i)) begin
                        activations[i*AW +: AW] <= y;
                        overflow_flags[i]       <= sum_overflow;
                    end
                end
            end
            if (state == FULL && activations_ready) begin
                count          <= '0;
                activations    <= '0;
                overflow_flags <= '0;
            end
        end
    end
endmodule
